// File: rtl/bjack_card_shoe_if.sv
// Card-shoe handshake bundle: draw/shuffle requests in, dealt card and deck status out.
interface bjack_card_shoe_if;
    logic       SHUFFLE;
    logic       DRAW;
    logic [3:0] CARD;
    logic       VALID;
    logic       BUSY;
    logic [5:0] LEFT;
    logic       EMPTY;

    modport master (
        output SHUFFLE, DRAW,
        input  CARD, VALID, BUSY, LEFT, EMPTY
    );

    modport slave (
        input  SHUFFLE, DRAW,
        output CARD, VALID, BUSY, LEFT, EMPTY
    );
endinterface

// File: rtl/bjack_card_shoe.sv
// Single-deck blackjack card shoe: deals one card value per draw from a shuffled
// 52-card deck, using an LFSR start point and a linear probe over per-value counts.
module bjack_card_shoe #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic              CLK,
    input  logic              RES,
    bjack_card_shoe_if.slave  bus
);

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned LEFT_W = 6;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned NVAL   = 10;

    localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [LEFT_W-1:0] FULL_LEFT = 6'd52;
    localparam logic [IDX_W-1:0]  LAST_IDX  = 4'd9;
    localparam logic [IDX_W-1:0]  TEN_IDX   = 4'd8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [LFSR_W-1:0]   w_lfsr_nxt;
    logic [CNT_W-1:0]    r_cnt     [NVAL];
    logic [CNT_W-1:0]    w_cnt_nxt [NVAL];
    logic [IDX_W-1:0]    r_cand;
    logic [IDX_W-1:0]    w_cand_nxt;
    logic [3:0]          r_card;
    logic [3:0]          w_card_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic [LEFT_W-1:0]   r_left;
    logic [LEFT_W-1:0]   w_left_nxt;
    logic                r_empty;
    logic                w_empty_nxt;
    logic [IDX_W-1:0]    w_start_idx;
    logic                w_accept;
    logic                w_hit;

    // Counter index 0..9 holds card value 2..11; index 8 is the ten-valued group.
    function automatic logic [CNT_W-1:0] full_cnt(input logic [IDX_W-1:0] idx);
        return (idx == TEN_IDX) ? 5'd16 : 5'd4;
    endfunction

    assign w_start_idx = (r_lfsr[3:0] < 4'd10) ? r_lfsr[3:0] : IDX_W'(r_lfsr[3:0] - 4'd10);
    assign w_accept    = (r_state == S_IDLE) && bus.DRAW && !bus.SHUFFLE && (r_left != '0);
    assign w_hit       = (r_state == S_SEARCH) && !bus.SHUFFLE && (r_cnt[r_cand] != '0);

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.SHUFFLE) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) w_state_nxt = S_SEARCH;
                S_SEARCH: if (w_hit)    w_state_nxt = S_IDLE;
                default:                w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath next values; shuffle overrides any draw or search in progress.
    always_comb begin
        w_lfsr_nxt  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_card_nxt  = r_card;
        w_valid_nxt = 1'b0;
        w_left_nxt  = r_left;
        if (bus.SHUFFLE) begin
            for (int unsigned i = 0; i < NVAL; i++) begin
                w_cnt_nxt[i] = full_cnt(IDX_W'(i));
            end
            w_left_nxt = FULL_LEFT;
        end else if (w_accept) begin
            w_cand_nxt = w_start_idx;
        end else if (w_hit) begin
            w_card_nxt        = 4'(r_cand + 4'd2);
            w_cnt_nxt[r_cand] = CNT_W'(r_cnt[r_cand] - 5'd1);
            w_left_nxt        = LEFT_W'(r_left - 6'd1);
            w_valid_nxt       = 1'b1;
        end else if (r_state == S_SEARCH) begin
            w_cand_nxt = (r_cand == LAST_IDX) ? '0 : IDX_W'(r_cand + 4'd1);
        end
        w_empty_nxt = (w_left_nxt == '0);
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_lfsr  <= SEED_EFF;
            for (int unsigned i = 0; i < NVAL; i++) begin
                r_cnt[i] <= full_cnt(IDX_W'(i));
            end
            r_cand  <= '0;
            r_card  <= '0;
            r_valid <= 1'b0;
            r_left  <= FULL_LEFT;
            r_empty <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            r_card  <= w_card_nxt;
            r_valid <= w_valid_nxt;
            r_left  <= w_left_nxt;
            r_empty <= w_empty_nxt;
        end
    end

    assign bus.CARD  = r_card;
    assign bus.VALID = r_valid;
    assign bus.BUSY  = (r_state == S_SEARCH);
    assign bus.LEFT  = r_left;
    assign bus.EMPTY = r_empty;

endmodule

// File: tb/tb_bjack_card_shoe.sv
// Directed bench for bjack_card_shoe: vector table for the first draws, then full-deck,
// shuffle and asynchronous-reset sequences.
module tb_bjack_card_shoe;

    logic CLK = 1'b0;
    logic RES = 1'b1;

    always #5 CLK = ~CLK;

    bjack_card_shoe_if if0 ();
    bjack_card_shoe_if if1 ();
    bjack_card_shoe_if if2 ();

    bjack_card_shoe #(.SEED(8'h05)) u0 (.CLK(CLK), .RES(RES), .bus(if0.slave));
    bjack_card_shoe #(.SEED(8'h0C)) u1 (.CLK(CLK), .RES(RES), .bus(if1.slave));
    bjack_card_shoe #(.SEED(8'h09)) u2 (.CLK(CLK), .RES(RES), .bus(if2.slave));

    typedef struct {
        logic       draw;
        logic       shf;
        logic       valid;
        logic       busy;
        logic [3:0] card;
        logic [5:0] left;
        logic       empty;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic b, input logic [3:0] c,
                           input logic [5:0] l, input logic e);
        chk({tag, ".VALID"}, 32'(if0.VALID), 32'(v));
        chk({tag, ".BUSY"},  32'(if0.BUSY),  32'(b));
        chk({tag, ".CARD"},  32'(if0.CARD),  32'(c));
        chk({tag, ".LEFT"},  32'(if0.LEFT),  32'(l));
        chk({tag, ".EMPTY"}, 32'(if0.EMPTY), 32'(e));
    endtask

    function automatic vec_t mk(input logic d, input logic s, input logic v, input logic b,
                                input logic [3:0] c, input logic [5:0] l, input logic e);
        vec_t r;
        r.draw = d; r.shf = s; r.valid = v; r.busy = b; r.card = c; r.left = l; r.empty = e;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hist [16];
        int nvalid, vrun, brun, max_vrun, max_brun, extra_valid, extra_busy, cyc;
        bit got;

        // SEED 05 LFSR sequence: 05,0A,15,2B,56 -> draws start at 7, 7, 8
        vecs[0]  = mk(1, 0, 0, 1, 4'd0, 6'd52, 0);
        vecs[1]  = mk(0, 0, 1, 0, 4'd7, 6'd51, 0);
        vecs[2]  = mk(1, 0, 0, 1, 4'd7, 6'd51, 0);
        vecs[3]  = mk(0, 0, 1, 0, 4'd7, 6'd50, 0);
        vecs[4]  = mk(1, 0, 0, 1, 4'd7, 6'd50, 0);
        vecs[5]  = mk(1, 0, 1, 0, 4'd8, 6'd49, 0);
        vecs[6]  = mk(0, 0, 0, 0, 4'd8, 6'd49, 0);
        vecs[7]  = mk(1, 1, 0, 0, 4'd8, 6'd52, 0);
        vecs[8]  = mk(0, 0, 0, 0, 4'd8, 6'd52, 0);
        vecs[9]  = mk(1, 0, 0, 1, 4'd8, 6'd52, 0);
        vecs[10] = mk(0, 1, 0, 0, 4'd8, 6'd52, 0);
        vecs[11] = mk(0, 0, 0, 0, 4'd8, 6'd52, 0);

        if0.DRAW = 0; if0.SHUFFLE = 0;
        if1.DRAW = 0; if1.SHUFFLE = 0;
        if2.DRAW = 0; if2.SHUFFLE = 0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RES = 0;
        chk_out("reset", 0, 0, 4'd0, 6'd52, 0);

        for (int i = 0; i < NVEC; i++) begin
            if0.DRAW    = vecs[i].draw;
            if0.SHUFFLE = vecs[i].shf;
            if1.DRAW    = (i == 0);
            if2.DRAW    = (i == 0);
            @(posedge CLK);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].busy, vecs[i].card,
                    vecs[i].left, vecs[i].empty);
            if (i == 1) begin
                chk("seed0C.CARD",  32'(if1.CARD),  32'd4);
                chk("seed0C.VALID", 32'(if1.VALID), 32'd1);
                chk("seed09.CARD",  32'(if2.CARD),  32'd11);
                chk("seed09.LEFT",  32'(if2.LEFT),  32'd51);
            end
            @(negedge CLK);
        end
        if0.DRAW = 0; if0.SHUFFLE = 0; if1.DRAW = 0; if2.DRAW = 0;

        // Drain the whole deck with DRAW held high
        RES = 1;
        @(posedge CLK);
        @(negedge CLK);
        RES = 0;
        for (int k = 0; k < 16; k++) hist[k] = 0;
        nvalid = 0; vrun = 0; brun = 0; max_vrun = 0; max_brun = 0; cyc = 0;
        if0.DRAW = 1;
        while (nvalid < 52 && cyc < 1000) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (if0.VALID) begin
                nvalid++;
                hist[if0.CARD]++;
                vrun++;
            end else begin
                vrun = 0;
            end
            brun = if0.BUSY ? brun + 1 : 0;
            if (vrun > max_vrun) max_vrun = vrun;
            if (brun > max_brun) max_brun = brun;
        end
        chk("drain.valid_count", 32'(nvalid), 32'd52);
        for (int v = 2; v <= 11; v++) begin
            chk($sformatf("hist[%0d]", v), 32'(hist[v]), (v == 10) ? 32'd16 : 32'd4);
        end
        chk("drain.max_valid_run", 32'(max_vrun), 32'd1);
        chk("drain.search_le_10", 32'(max_brun <= 10), 32'd1);

        extra_valid = 0; extra_busy = 0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (if0.VALID) extra_valid++;
            if (if0.BUSY)  extra_busy++;
        end
        chk("empty.extra_valid", 32'(extra_valid), 32'd0);
        chk("empty.extra_busy",  32'(extra_busy),  32'd0);
        chk("empty.EMPTY", 32'(if0.EMPTY), 32'd1);
        chk("empty.LEFT",  32'(if0.LEFT),  32'd0);

        // Shuffle refills, then a normal draw
        @(negedge CLK);
        if0.DRAW = 0; if0.SHUFFLE = 1;
        @(posedge CLK);
        #1;
        chk("shuffle.LEFT",  32'(if0.LEFT),  32'd52);
        chk("shuffle.EMPTY", 32'(if0.EMPTY), 32'd0);
        @(negedge CLK);
        if0.SHUFFLE = 0; if0.DRAW = 1;
        @(posedge CLK);
        #1;
        chk("redraw.BUSY", 32'(if0.BUSY), 32'd1);
        @(negedge CLK);
        if0.DRAW = 0;
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(posedge CLK);
            #1;
            if (if0.VALID) got = 1;
        end
        chk("redraw.got_valid", 32'(got), 32'd1);
        chk("redraw.LEFT", 32'(if0.LEFT), 32'd51);
        chk("redraw.card_range", 32'(if0.CARD >= 4'd2 && if0.CARD <= 4'd11), 32'd1);

        // Asynchronous reset between edges during a search
        @(negedge CLK);
        if0.DRAW = 1;
        @(posedge CLK);
        #1;
        chk("ares.BUSY_before", 32'(if0.BUSY), 32'd1);
        if0.DRAW = 0;
        #2;
        RES = 1;
        #1;
        chk_out("ares", 0, 0, 4'd0, 6'd52, 0);
        @(posedge CLK);
        @(negedge CLK);
        RES = 0;
        if0.DRAW = 1;
        @(posedge CLK);
        #1;
        chk("ares.redraw_BUSY", 32'(if0.BUSY), 32'd1);
        @(negedge CLK);
        if0.DRAW = 0;
        @(posedge CLK);
        #1;
        chk("ares.seed_CARD",  32'(if0.CARD),  32'd7);
        chk("ares.seed_VALID", 32'(if0.VALID), 32'd1);
        chk("ares.seed_LEFT",  32'(if0.LEFT),  32'd51);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
